// File: rtl/exp20_pkg.sv
// ----------------------------------------------------------------------------
// exp20_pkg : shared FSM state encoding and sizing constants for exp20_top
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package exp20_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_DATA_W = 16;
  localparam int OP_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    MUL  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/exp20_sdiv.sv
// ----------------------------------------------------------------------------
// exp20_sdiv : signed 8-bit sequential divider, one restoring step per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exp20_sdiv
  import exp20_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [OP_W-1:0] dividend_i,
  input  logic [OP_W-1:0] divisor_i,
  output logic            last_o,
  output logic [OP_W-1:0] quot_o,
  output logic [OP_W-1:0] rem_o
);

  logic [OP_W-1:0] dvd_q, dvd_d;
  logic [OP_W-1:0] rem_q, rem_d;
  logic [OP_W-1:0] dsr_q, dsr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [OP_W:0]   trial;
  logic            ge;

  // Magnitudes are unsigned 8-bit (0..128), so -128 needs no special case.
  // A zero divisor never subtracts: quotient stays 0 and the dividend bits
  // shift straight into the remainder.
  always_comb begin
    trial = {rem_q, dvd_q[OP_W-1]};
    ge    = (dsr_q != '0) && (trial >= {1'b0, dsr_q});
    dvd_d = dvd_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    if (load_i) begin
      sa_d  = dividend_i[OP_W-1];
      sb_d  = divisor_i[OP_W-1];
      dvd_d = dividend_i[OP_W-1] ? ('0 - dividend_i) : dividend_i;
      dsr_d = divisor_i[OP_W-1] ? ('0 - divisor_i) : divisor_i;
      rem_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      dvd_d = {dvd_q[OP_W-2:0], ge};
      rem_d = ge ? (trial[OP_W-1:0] - dsr_q) : trial[OP_W-1:0];
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
    end
  end

  assign last_o = (cnt_q == 3'd7);
  assign quot_o = (sa_q ^ sb_q) ? ('0 - dvd_q) : dvd_q;
  assign rem_o  = sa_q ? ('0 - rem_q) : rem_q;

endmodule

`default_nettype wire

// File: rtl/exp20_top.sv
// ----------------------------------------------------------------------------
// exp20_top : operand FIFO feeding a signed divider; reports quotient*remainder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exp20_top
  import exp20_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_req,
  input  logic [DATA_W-1:0] fifo_write_data,
  output logic [4:0]        a_left_sig,
  output logic [DATA_W-1:0] product
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [4:0]        left_q, left_d;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] product_q, product_d;
  state_e            state_q, state_d;

  logic              empty, push, pop, load, step, last;
  logic [OP_W-1:0]   quot, rem;
  logic [DATA_W-1:0] quot_ext, rem_ext;

  assign empty  = (left_q == 5'(DEPTH));
  assign push   = write_req && (left_q != '0);
  assign left_d = left_q - 5'(push) + 5'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      left_q    <= 5'(DEPTH);
      word_q    <= '0;
      product_q <= '0;
      state_q   <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        word_q   <= mem_q[rd_ptr_q];
      end
      left_q    <= left_d;
      product_q <= product_d;
      state_q   <= state_d;
    end
  end

  assign quot_ext = {{(DATA_W-OP_W){quot[OP_W-1]}}, quot};
  assign rem_ext  = {{(DATA_W-OP_W){rem[OP_W-1]}}, rem};

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    pop       = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = DIV;
      end
      DIV: begin
        step = 1'b1;
        if (last) state_d = MUL;
      end
      MUL: begin
        product_d = quot_ext * rem_ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  exp20_sdiv u_sdiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (word_q[DATA_W-1 -: OP_W]),
    .divisor_i  (word_q[OP_W-1:0]),
    .last_o     (last),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  assign a_left_sig = left_q;
  assign product    = product_q;

endmodule

`default_nettype wire

// File: tb/tb_exp20_top.sv
// ----------------------------------------------------------------------------
// tb_exp20_top : randomized scoreboard bench for exp20_top
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exp20_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_req = 1'b0;
  logic [15:0] fifo_write_data = '0;
  logic [4:0]  a_left_sig;
  logic [15:0] product;

  exp20_top #(.DEPTH(16), .DATA_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .write_req       (write_req),
    .fifo_write_data (fifo_write_data),
    .a_left_sig      (a_left_sig),
    .product         (product)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  left;
    logic [15:0] prod;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          mon_cyc = 0;

  // Reference model: queue of words, an engine that is busy for a fixed
  // number of edges after taking an entry, and the last reported product.
  logic [15:0] m_fifo[$];
  int          m_busy = 0;
  logic [15:0] m_pending = '0;
  logic [15:0] m_prod = '0;

  function automatic logic [15:0] ref_product(input logic [15:0] w);
    int a, b, q, r, qi, ri;
    logic [7:0] q8, r8;
    a = $signed(w[15:8]);
    b = $signed(w[7:0]);
    if (b == 0) begin
      q = 0;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    q8 = q[7:0];
    r8 = r[7:0];
    qi = $signed(q8);
    ri = $signed(r8);
    return 16'(qi * ri);
  endfunction

  task automatic step(input logic rst_val, input logic req, input logic [15:0] data);
    bit   pop_ok, push_ok;
    exp_t e;
    @(negedge clk);
    rst_n           = rst_val;
    write_req       = req;
    fifo_write_data = data;
    if (!rst_val) begin
      m_fifo.delete();
      m_busy    = 0;
      m_pending = '0;
      m_prod    = '0;
    end else begin
      pop_ok  = (m_busy == 0) && (m_fifo.size() > 0);
      push_ok = req && (m_fifo.size() < 16);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_prod = m_pending;
      end
      if (pop_ok) begin
        m_pending = ref_product(m_fifo.pop_front());
        m_busy    = 10;
      end
      if (push_ok) m_fifo.push_back(data);
    end
    e.left = 5'(16 - m_fifo.size());
    e.prod = m_prod;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (a_left_sig !== mon_e.left) begin
        failures++;
        $display("FAIL a_left_sig cyc=%0d actual=%0d expected=%0d", mon_cyc, a_left_sig, mon_e.left);
      end
      checks++;
      if (product !== mon_e.prod) begin
        failures++;
        $display("FAIL product cyc=%0d actual=%h expected=%h", mon_cyc, product, mon_e.prod);
      end
    end
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] d;
    int sel;
    d   = 16'($urandom);
    sel = $urandom_range(0, 7);
    if (sel == 0) d[7:0] = 8'h00;
    else if (sel == 1) d[15:8] = 8'h80;
    else if (sel == 2) d[7:0] = 8'hFF;
    return d;
  endfunction

  initial begin
    repeat (3) step(1'b0, 1'b0, '0);

    // Directed operand set, including the sign cases
    step(1'b1, 1'b1, {8'd45, 8'd2});
    step(1'b1, 1'b1, {8'd23, 8'd12});
    step(1'b1, 1'b1, {8'd15, 8'hFA});
    repeat (40) step(1'b1, 1'b0, '0);

    step(1'b1, 1'b1, {8'd7, 8'd0});
    step(1'b1, 1'b1, {8'h80, 8'd1});
    step(1'b1, 1'b1, {8'hF9, 8'd2});
    step(1'b1, 1'b1, {8'h80, 8'hFF});
    step(1'b1, 1'b1, {8'h80, 8'h00});
    step(1'b1, 1'b1, {8'd127, 8'h80});
    repeat (80) step(1'b1, 1'b0, '0);

    // Reset while the first entry is mid-divide, with a second one queued
    step(1'b1, 1'b1, {8'd45, 8'd2});
    step(1'b1, 1'b1, {8'd99, 8'd5});
    repeat (4) step(1'b1, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, {8'd100, 8'd7});
    repeat (20) step(1'b1, 1'b0, '0);

    // Continuous pushes until the FIFO fills and further words are dropped
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, rand_word());
    repeat (200) step(1'b1, 1'b0, '0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) step(1'b0, 1'b0, '0);
      else step(1'b1, ($urandom_range(0, 3) == 0), rand_word());
    end
    repeat (200) step(1'b1, 1'b0, '0);

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
